dtlb_assoc: RTL and testbench

//  Parametrised fully-associative data TLB with runtime refill. Translates up to two virtual

---
 rtl/dtlb_assoc_pkg.sv | 16 +
 rtl/dtlb_victim_sel.sv | 19 +
 rtl/dtlb_assoc.sv | 147 ++++++++++++++
 tb/tb_dtlb_assoc.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dtlb_assoc_pkg.sv
// Shared constants and types for the data TLB.
// Default widths and boot mappings are common with the itlb.
package dtlb_assoc_pkg;
  localparam int DTLB_VPN_BITS = 9;
  localparam int DTLB_PPN_BITS = 9;
  localparam int DTLB_ENTRIES  = 4;
  localparam logic [8:0] DTLB_RST_VPN0 = 9'h010;
  localparam logic [8:0] DTLB_RST_PPN0 = 9'h000;
  localparam logic [8:0] DTLB_RST_VPN1 = 9'h011;
  localparam logic [8:0] DTLB_RST_PPN1 = 9'h009;

  typedef enum logic {
    S_IDLE,
    S_PEND
  } miss_st_e;
endpackage

// File: rtl/dtlb_victim_sel.sv
// Refill slot choice: lowest invalid entry, else the round-robin victim.
// o_evict flags that a valid entry is about to be replaced.
module dtlb_victim_sel #(
  parameter int NUM_ENTRIES = 4,
  parameter int IDX_BITS    = $clog2(NUM_ENTRIES)
) (
  input  logic [NUM_ENTRIES-1:0] i_valid,
  input  logic [IDX_BITS-1:0]    i_rr_ptr,
  output logic [IDX_BITS-1:0]    o_victim,
  output logic                   o_evict
);
  always_comb begin
    o_evict  = &i_valid;
    o_victim = i_rr_ptr;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!i_valid[i]) o_victim = IDX_BITS'(i);
    end
  end
endmodule

// File: rtl/dtlb_assoc.sv
// Fully-associative data TLB: two lookup ports, refill,
// invalidate, flush and a held miss request.
module dtlb_assoc
  import dtlb_assoc_pkg::*;
#(
  parameter int VPN_BITS    = DTLB_VPN_BITS,
  parameter int PPN_BITS    = DTLB_PPN_BITS,
  parameter int NUM_ENTRIES = DTLB_ENTRIES,
  parameter logic [VPN_BITS-1:0] RST_VPN0 = DTLB_RST_VPN0,
  parameter logic [PPN_BITS-1:0] RST_PPN0 = DTLB_RST_PPN0,
  parameter logic [VPN_BITS-1:0] RST_VPN1 = DTLB_RST_VPN1,
  parameter logic [PPN_BITS-1:0] RST_PPN1 = DTLB_RST_PPN1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_is_word_access,
  input  logic [VPN_BITS-1:0] i_vpn0,
  input  logic [VPN_BITS-1:0] i_vpn1,
  output logic [PPN_BITS-1:0] o_ppn0,
  output logic [PPN_BITS-1:0] o_ppn1,
  output logic                o_hit,
  output logic [VPN_BITS-1:0] o_offending_vpn,
  output logic                o_miss_req,
  output logic [VPN_BITS-1:0] o_miss_vpn,
  input  logic                i_wr_en,
  input  logic [VPN_BITS-1:0] i_wr_vpn,
  input  logic [PPN_BITS-1:0] i_wr_ppn,
  input  logic                i_inv_en,
  input  logic [VPN_BITS-1:0] i_inv_vpn,
  input  logic                i_flush
);
  localparam int IDX_BITS = $clog2(NUM_ENTRIES);

  logic [VPN_BITS-1:0]    r_tag [NUM_ENTRIES];
  logic [PPN_BITS-1:0]    r_ppn [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] r_valid;
  logic [IDX_BITS-1:0]    r_rr_ptr;
  miss_st_e               r_state;
  miss_st_e               w_state_nxt;
  logic [VPN_BITS-1:0]    r_miss_vpn;
  logic [VPN_BITS-1:0]    w_miss_vpn_nxt;

  logic [NUM_ENTRIES-1:0] w_m0, w_m1, w_wm, w_im;
  logic                   w_hit0, w_hit1, w_wany;
  logic [IDX_BITS-1:0]    w_widx, w_victim, w_wr_idx;
  logic                   w_evict;

  genvar g;
  generate
    for (g = 0; g < NUM_ENTRIES; g++) begin : g_cmp
      assign w_m0[g] = r_valid[g] && (r_tag[g] == i_vpn0);
      assign w_m1[g] = r_valid[g] && (r_tag[g] == i_vpn1);
      assign w_wm[g] = r_valid[g] && (r_tag[g] == i_wr_vpn);
      assign w_im[g] = r_valid[g] && (r_tag[g] == i_inv_vpn);
    end
  endgenerate

  // Descending scan so the lowest matching index wins
  always_comb begin
    o_ppn0 = '0;
    o_ppn1 = '0;
    w_widx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (w_m0[i]) o_ppn0 = r_ppn[i];
      if (w_m1[i]) o_ppn1 = r_ppn[i];
      if (w_wm[i]) w_widx = IDX_BITS'(i);
    end
  end

  assign w_hit0 = |w_m0;
  assign w_hit1 = |w_m1;
  assign w_wany = |w_wm;
  assign o_hit  = w_hit0 && (!i_is_word_access || w_hit1);
  assign o_offending_vpn = w_hit0 ? i_vpn1 : i_vpn0;

  dtlb_victim_sel #(
    .NUM_ENTRIES(NUM_ENTRIES),
    .IDX_BITS   (IDX_BITS)
  ) u_vsel (
    .i_valid (r_valid),
    .i_rr_ptr(r_rr_ptr),
    .o_victim(w_victim),
    .o_evict (w_evict)
  );

  assign w_wr_idx = w_wany ? w_widx : w_victim;

  // Write is ordered after invalidate so it wins on the same VPN
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_ppn[i]   <= '0;
      end
      r_tag[0]   <= RST_VPN0;
      r_ppn[0]   <= RST_PPN0;
      r_valid[0] <= 1'b1;
      r_tag[1]   <= RST_VPN1;
      r_ppn[1]   <= RST_PPN1;
      r_valid[1] <= 1'b1;
      r_rr_ptr   <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else begin
      if (i_inv_en) r_valid <= r_valid & ~w_im;
      if (i_wr_en) begin
        r_tag[w_wr_idx]   <= i_wr_vpn;
        r_ppn[w_wr_idx]   <= i_wr_ppn;
        r_valid[w_wr_idx] <= 1'b1;
        if (!w_wany && w_evict)
          r_rr_ptr <= r_rr_ptr + IDX_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_miss_vpn <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_miss_vpn <= w_miss_vpn_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_miss_vpn_nxt = r_miss_vpn;
    unique case (r_state)
      S_IDLE: begin
        if (!i_flush && !o_hit) begin
          w_state_nxt    = S_PEND;
          w_miss_vpn_nxt = o_offending_vpn;
        end
      end
      S_PEND: begin
        if (i_flush || (i_wr_en && i_wr_vpn == r_miss_vpn))
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_miss_req = (r_state == S_PEND);
  assign o_miss_vpn = r_miss_vpn;
endmodule

// File: tb/tb_dtlb_assoc.sv
// Scoreboard bench for dtlb_assoc: directed steps queue
// expectations tagged by cycle; a monitor checks them mid-cycle.
module tb_dtlb_assoc;
  logic       clk = 1'b0;
  logic       reset;
  logic       word;
  logic [8:0] vpn0, vpn1;
  logic [8:0] ppn0, ppn1;
  logic       hit;
  logic [8:0] offv;
  logic       mreq;
  logic [8:0] mvpn;
  logic       wr_en;
  logic [8:0] wr_vpn, wr_ppn;
  logic       inv_en;
  logic [8:0] inv_vpn;
  logic       flush;

  dtlb_assoc dut (
    .clk             (clk),
    .reset           (reset),
    .i_is_word_access(word),
    .i_vpn0          (vpn0),
    .i_vpn1          (vpn1),
    .o_ppn0          (ppn0),
    .o_ppn1          (ppn1),
    .o_hit           (hit),
    .o_offending_vpn (offv),
    .o_miss_req      (mreq),
    .o_miss_vpn      (mvpn),
    .i_wr_en         (wr_en),
    .i_wr_vpn        (wr_vpn),
    .i_wr_ppn        (wr_ppn),
    .i_inv_en        (inv_en),
    .i_inv_vpn       (inv_vpn),
    .i_flush         (flush)
  );

  always #5 clk = ~clk;

  typedef enum int {
    F_PPN0, F_PPN1, F_HIT, F_OFF, F_MREQ, F_MVPN
  } fld_e;

  typedef struct {
    int    cyc;
    string name;
    fld_e  f;
    int    exp;
  } item_t;

  item_t sbq[$];
  int    cyc = 0;
  int    total = 0;
  int    bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pick(fld_e f);
    case (f)
      F_PPN0: return int'(ppn0);
      F_PPN1: return int'(ppn1);
      F_HIT:  return int'(hit);
      F_OFF:  return int'(offv);
      F_MREQ: return int'(mreq);
      default: return int'(mvpn);
    endcase
  endfunction

  always @(negedge clk) begin
    item_t it;
    int act;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      it = sbq.pop_front();
      total++;
      if (it.cyc < cyc) begin
        bad++;
        $display("FAIL %s: stale check at cyc %0d", it.name, cyc);
      end else begin
        act = pick(it.f);
        if (act != it.exp) begin
          bad++;
          $display("FAIL %s: got %0h want %0h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic chk(string n, fld_e f, int e);
    item_t it;
    it.cyc = cyc; it.name = n; it.f = f; it.exp = e;
    sbq.push_back(it);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    word = 0; vpn0 = 9'h010; vpn1 = 9'h010;
    wr_en = 0; wr_vpn = 0; wr_ppn = 0;
    inv_en = 0; inv_vpn = 0; flush = 0;
  endtask

  task automatic wr(logic [8:0] v, logic [8:0] p);
    wr_en = 1; wr_vpn = v; wr_ppn = p;
  endtask

  initial begin
    reset = 1;
    idle_in();
    step(); step();
    // boot mappings
    reset = 0;
    chk("rst_ppn0", F_PPN0, 'h000);
    chk("rst_hit", F_HIT, 1);
    chk("rst_mreq", F_MREQ, 0);
    chk("rst_mvpn", F_MVPN, 0);
    step(); vpn0 = 9'h011;
    chk("boot1_ppn0", F_PPN0, 'h009);
    chk("boot1_hit", F_HIT, 1);
    // port 1 miss
    step(); word = 1; vpn0 = 9'h010; vpn1 = 9'h020;
    chk("p1miss_hit", F_HIT, 0);
    chk("p1miss_off", F_OFF, 'h020);
    chk("p1miss_ppn1", F_PPN1, 0);
    chk("p1miss_ppn0", F_PPN0, 'h000);
    step(); word = 0; vpn0 = 9'h030;
    chk("p0miss_off", F_OFF, 'h030);
    chk("pend_mreq", F_MREQ, 1);
    chk("pend_mvpn", F_MVPN, 'h020);
    step(); vpn0 = 9'h010;
    chk("frozen_mvpn", F_MVPN, 'h020);
    // refill into entry2
    step(); wr(9'h020, 9'h030);
    chk("refill_mreq_held", F_MREQ, 1);
    step(); idle_in(); word = 1; vpn1 = 9'h020;
    chk("refill_ppn1", F_PPN1, 'h030);
    chk("refill_hit", F_HIT, 1);
    chk("refill_mreq_clr", F_MREQ, 0);
    // fill and evict 0, 1
    step(); idle_in(); wr(9'h050, 9'h055);
    step(); wr(9'h040, 9'h044); vpn0 = 9'h011;
    chk("pre_evict_hit", F_HIT, 1);
    step(); wr(9'h041, 9'h045); vpn0 = 9'h040;
    chk("ev0_ppn0", F_PPN0, 'h044);
    step(); idle_in(); vpn0 = 9'h041;
    chk("ev1_ppn0", F_PPN0, 'h045);
    step(); vpn0 = 9'h010;
    chk("evicted_hit", F_HIT, 0);
    chk("evicted_off", F_OFF, 'h010);
    chk("evicted_ppn0", F_PPN0, 0);
    step(); vpn0 = 9'h050;
    chk("e3_ppn0", F_PPN0, 'h055);
    chk("miss010_mvpn", F_MVPN, 'h010);
    // rr_ptr == 2: next victim is entry2 (0x020)
    step(); wr(9'h060, 9'h066);
    step(); idle_in(); word = 1;
    vpn0 = 9'h060; vpn1 = 9'h020;
    chk("rr2_ppn0", F_PPN0, 'h066);
    chk("rr2_hit", F_HIT, 0);
    chk("rr2_off", F_OFF, 'h020);
    // overwrite existing VPN, no slot used
    step(); idle_in(); vpn0 = 9'h050; wr(9'h041, 9'h0AA);
    step(); idle_in(); word = 1;
    vpn0 = 9'h041; vpn1 = 9'h050;
    chk("dedup_ppn0", F_PPN0, 'h0AA);
    chk("dedup_ppn1", F_PPN1, 'h055);
    step(); idle_in(); vpn0 = 9'h040; wr(9'h070, 9'h077);
    step(); idle_in(); word = 1;
    vpn0 = 9'h060; vpn1 = 9'h050;
    chk("rr3_ppn0", F_PPN0, 'h066);
    chk("rr3_hit", F_HIT, 0);
    chk("rr3_ppn1", F_PPN1, 0);
    step(); vpn0 = 9'h070; vpn1 = 9'h041;
    chk("dual_ppn0", F_PPN0, 'h077);
    chk("dual_ppn1", F_PPN1, 'h0AA);
    chk("dual_hit", F_HIT, 1);
    chk("still_pend", F_MREQ, 1);
    // refill the pending 0x010
    step(); idle_in(); vpn0 = 9'h040; wr(9'h010, 9'h0BB);
    step(); idle_in();
    chk("r010_ppn0", F_PPN0, 'h0BB);
    chk("r010_mreq", F_MREQ, 0);
    // invalidate
    step(); inv_en = 1; inv_vpn = 9'h070;
    step(); idle_in(); vpn0 = 9'h070;
    chk("inv_hit", F_HIT, 0);
    chk("inv_ppn0", F_PPN0, 0);
    step(); idle_in();
    chk("inv_mvpn", F_MVPN, 'h070);
    step(); inv_en = 1; inv_vpn = 9'h041; wr(9'h041, 9'h0CC);
    step(); idle_in(); vpn0 = 9'h041;
    chk("invwr_ppn0", F_PPN0, 'h0CC);
    chk("invwr_hit", F_HIT, 1);
    step(); idle_in(); wr(9'h080, 9'h088);
    step(); idle_in(); word = 1;
    vpn0 = 9'h080; vpn1 = 9'h060;
    chk("fillinv_ppn0", F_PPN0, 'h088);
    chk("fillinv_ppn1", F_PPN1, 'h066);
    chk("fillinv_hit", F_HIT, 1);
    // flush with write
    step(); idle_in(); flush = 1; wr(9'h090, 9'h099);
    chk("fl_mreq_before", F_MREQ, 1);
    step(); idle_in();
    chk("fl_hit", F_HIT, 0);
    chk("fl_ppn0", F_PPN0, 0);
    chk("fl_mreq", F_MREQ, 0);
    step(); word = 1; vpn0 = 9'h090; vpn1 = 9'h080;
    chk("fl_drop_hit", F_HIT, 0);
    chk("fl_drop_off", F_OFF, 'h090);
    chk("fl_pend_mvpn", F_MVPN, 'h010);
    // reset during pending miss
    step(); idle_in(); reset = 1;
    step();
    step(); reset = 0; vpn0 = 9'h011;
    chk("rr_ppn0", F_PPN0, 'h009);
    chk("rr_hit", F_HIT, 1);
    chk("rr_mreq", F_MREQ, 0);
    chk("rr_mvpn", F_MVPN, 0);
    step(); vpn0 = 9'h010;
    chk("rr_boot0", F_PPN0, 'h000);
    step(); step();
    @(negedge clk); #1;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: left=%0d want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
